four_one_rr_mux: RTL

- Fan-in counterpart of the 1-to-4 demultiplexer: merges four valid/ready input channels onto one output channel.
- Arbitration is round-robin, with a single registered output stage.
- Sits wherever four producers share one consumer, e.g. re-joining lanes previously split by select-driven demux logic.
- Sustains one transfer per cycle with fair access for all four inputs.

---
 rtl/four_one_rr_mux.sv | 124 ++++++++++++
 1 files changed

// File: rtl/four_one_rr_mux.sv
// Four-input round-robin merge onto one registered valid/ready output stage.
// Optional packet locking (in_last/out_last) is enabled by defining FOUR_ONE_PKT_LOCK_EN.
module four_one_rr_mux #(
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      in_valid,
  input  logic [4*DW-1:0] in_data,
`ifdef FOUR_ONE_PKT_LOCK_EN
  input  logic [3:0]      in_last,
  output logic            out_last,
`endif
  output logic [3:0]      in_ready,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  output logic [1:0]      out_sel,
  input  logic            out_ready
);

  logic [3:0]    rot_s;
  logic [1:0]    off_s;
  logic [1:0]    winner_s;
  logic          gnt_v_s;
  logic          ld_s;
  logic          xfer_s;
  logic [1:0]    ptr_r;
  logic          out_valid_r;
  logic [DW-1:0] out_data_r;
  logic [1:0]    out_sel_r;
`ifdef FOUR_ONE_PKT_LOCK_EN
  logic          lock_r;
  logic [1:0]    lock_ch_r;
  logic          out_last_r;
  logic          win_last_s;
`endif

  // Rotate requests so bit 0 is the current priority holder, then find the first requester
  always_comb begin
    rot_s = 4'b0000;
    off_s = 2'd0;
    rot_s = 4'({in_valid, in_valid} >> ptr_r);
    casez (rot_s)
      4'b???1: off_s = 2'd0;
      4'b??10: off_s = 2'd1;
      4'b?100: off_s = 2'd2;
      4'b1000: off_s = 2'd3;
      default: off_s = 2'd0;
    endcase
  end

  // Winner, load enable and per-channel ready; a locked packet pins the winner
  always_comb begin
    ld_s     = ~out_valid_r | out_ready;
    winner_s = ptr_r + off_s;
    gnt_v_s  = |in_valid;
`ifdef FOUR_ONE_PKT_LOCK_EN
    win_last_s = 1'b0;
    if (lock_r) begin
      winner_s = lock_ch_r;
      gnt_v_s  = in_valid[lock_ch_r];
    end else begin
      winner_s = ptr_r + off_s;
      gnt_v_s  = |in_valid;
    end
    win_last_s = in_last[winner_s];
`endif
    xfer_s   = ld_s & gnt_v_s & rst_n;
    in_ready = xfer_s ? (4'b0001 << winner_s) : 4'b0000;
  end

  // Output register, priority pointer and packet-lock state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {DW{1'b0}};
      out_sel_r   <= 2'd0;
      ptr_r       <= 2'd0;
`ifdef FOUR_ONE_PKT_LOCK_EN
      lock_r      <= 1'b0;
      lock_ch_r   <= 2'd0;
      out_last_r  <= 1'b0;
`endif
    end else if (xfer_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= in_data[int'(winner_s)*DW +: DW];
      out_sel_r   <= winner_s;
`ifdef FOUR_ONE_PKT_LOCK_EN
      out_last_r  <= win_last_s;
      if (lock_r) begin
        // Priority stays frozen inside a packet and resumes after its owner
        if (win_last_s) begin
          lock_r <= 1'b0;
          ptr_r  <= lock_ch_r + 2'd1;
        end else begin
          ptr_r  <= ptr_r;
        end
      end else begin
        ptr_r <= winner_s + 2'd1;
        if (!win_last_s) begin
          lock_r    <= 1'b1;
          lock_ch_r <= winner_s;
        end else begin
          lock_r    <= 1'b0;
        end
      end
`else
      ptr_r <= winner_s + 2'd1;
`endif
    end else if (ld_s) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_sel   = out_sel_r;
`ifdef FOUR_ONE_PKT_LOCK_EN
  assign out_last  = out_last_r;
`endif

endmodule
